systolic_feeder: RTL

- Edge driver for the N×N systolic MAC grid.
- Buffers operand matrices A (rows feed west edge) and B (columns feed north edge), then streams them diagonally skewed so every processing element sees matching A[i][k], B[k][j] pairs in the same cycle.
- Clears the grid accumulators before each run and flags completion once the far-corner element has accumulated its last product.
- Sits between the host/register interface and the grid's west_input/north_input edges.

---
 rtl/systolic_pkg.sv | 21 ++
 rtl/feeder_bank.sv | 48 ++++
 rtl/systolic_feeder.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared constants, state type and edge-bus helper for the systolic grid feeder.
package systolic_pkg;

  localparam int DEF_N      = 4;
  localparam int DEF_DATA_W = 16;
  localparam int ACC_W      = 2 * DEF_DATA_W;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    FIN
  } feeder_state_e;

  // Lowest bit of lane `lane` in a packed edge bus built from `width`-bit lanes.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/feeder_bank.sv
// N x N operand register file with one write port and an N-lane diagonally skewed read port.
// COL_MAJOR=0 reads lane i = M[i][s-i] (west edge); COL_MAJOR=1 reads lane j = M[s-j][j] (north edge).
module feeder_bank
  import systolic_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int COL_MAJOR = 0,
  parameter int IDX_W     = $clog2(N),
  parameter int S_W       = $clog2(2 * N)
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_row,
  input  logic [IDX_W-1:0]    wr_col,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [S_W-1:0]      rd_s,
  output logic [N*DATA_W-1:0] rd_lanes
);

  logic [DATA_W-1:0] mem [N][N];

  // NOTE: the operand array is deliberately left out of reset; every element is loaded
  // before use, and a reset would only add a clear path to each storage flop.
  // Sequential state is always updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_row][wr_col] <= wr_data;
  end

  for (genvar l = 0; l < N; l++) begin : g_lane
    logic [S_W:0]      off;
    logic [DATA_W-1:0] val;

    // NOTE: val gets a default before any branch so this block never infers a latch.
    always_comb begin
      off = {1'b0, rd_s} - (S_W + 1)'(l);
      val = '0;
      // A negative s-l wraps into the top bit, so one compare covers both bounds.
      if (off < (S_W + 1)'(N)) begin
        if (COL_MAJOR != 0) val = mem[off[IDX_W-1:0]][l];
        else                val = mem[l][off[IDX_W-1:0]];
      end
    end

    assign rd_lanes[lane_lsb(l, DATA_W) +: DATA_W] = val;
  end

endmodule

// File: rtl/systolic_feeder.sv
// Edge driver for an N x N systolic MAC grid: buffers A and B, clears the grid, streams skewed operands.
// Define SYSTOLIC_FEEDER_PINGPONG_EN for double-buffered operands that accept writes during runs.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic                 wr_sel,
  input  logic [$clog2(N)-1:0] wr_row,
  input  logic [$clog2(N)-1:0] wr_col,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 array_clr,
  output logic [N*DATA_W-1:0]  west_out,
  output logic [N*DATA_W-1:0]  north_out
);

  localparam int IDX_W = $clog2(N);
  localparam int S_W   = $clog2(2 * N);

  feeder_state_e       state_q, state_d;
  logic [S_W-1:0]      cnt_q, cnt_d;
  logic                wr_in_range;
  logic                wr_acc;
  logic [N*DATA_W-1:0] west_rd, north_rd;

  assign wr_in_range = ({1'b0, wr_row} < (IDX_W + 1)'(N)) &&
                       ({1'b0, wr_col} < (IDX_W + 1)'(N));
  assign wr_acc      = wr_valid && wr_ready && wr_in_range;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == S_W'(N - 1)) begin
          state_d = STREAM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STREAM: begin
        if (cnt_q == S_W'(2 * N - 2)) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_q == S_W'(N - 2)) begin
          state_d = FIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Lanes are loaded from the next stream index so cycle s shows skew step s from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      west_out  <= '0;
      north_out <= '0;
    end else begin
      west_out  <= (state_d == STREAM) ? west_rd  : '0;
      north_out <= (state_d == STREAM) ? north_rd : '0;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign array_clr = (state_q == CLEAR);

`ifdef SYSTOLIC_FEEDER_PINGPONG_EN
  logic                start_acc;
  logic                wr_bank_q;
  logic [N*DATA_W-1:0] west_bk  [2];
  logic [N*DATA_W-1:0] north_bk [2];

  assign start_acc = (state_q == IDLE) && start;
  assign wr_ready  = 1'b1;

  // Writes land in wr_bank_q; a run reads the other bank, which was the write bank before start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            wr_bank_q <= 1'b0;
    else if (start_acc) wr_bank_q <= ~wr_bank_q;
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic bank_wr;
    assign bank_wr = wr_acc && (wr_bank_q == 1'(b));

    feeder_bank #(.N(N), .DATA_W(DATA_W), .COL_MAJOR(0)) u_bank_a (
      .clk      (clk),
      .wr_en    (bank_wr && !wr_sel),
      .wr_row   (wr_row),
      .wr_col   (wr_col),
      .wr_data  (wr_data),
      .rd_s     (cnt_d),
      .rd_lanes (west_bk[b])
    );

    feeder_bank #(.N(N), .DATA_W(DATA_W), .COL_MAJOR(1)) u_bank_b (
      .clk      (clk),
      .wr_en    (bank_wr && wr_sel),
      .wr_row   (wr_row),
      .wr_col   (wr_col),
      .wr_data  (wr_data),
      .rd_s     (cnt_d),
      .rd_lanes (north_bk[b])
    );
  end

  assign west_rd  = west_bk[~wr_bank_q];
  assign north_rd = north_bk[~wr_bank_q];
`else
  assign wr_ready = !busy;

  feeder_bank #(.N(N), .DATA_W(DATA_W), .COL_MAJOR(0)) u_bank_a (
    .clk      (clk),
    .wr_en    (wr_acc && !wr_sel),
    .wr_row   (wr_row),
    .wr_col   (wr_col),
    .wr_data  (wr_data),
    .rd_s     (cnt_d),
    .rd_lanes (west_rd)
  );

  feeder_bank #(.N(N), .DATA_W(DATA_W), .COL_MAJOR(1)) u_bank_b (
    .clk      (clk),
    .wr_en    (wr_acc && wr_sel),
    .wr_row   (wr_row),
    .wr_col   (wr_col),
    .wr_data  (wr_data),
    .rd_s     (cnt_d),
    .rd_lanes (north_rd)
  );
`endif

endmodule
